// File: rtl/thor2023_icache_refill_ctrl.sv
// Instruction-cache refill sequencer: fetches a missing line as BEATS memory
// beats, assembles it, and writes it into a round-robin selected way.
module thor2023_icache_refill_ctrl #(
  parameter int AWID      = 32,
  parameter int ASIDW     = 16,
  parameter int LINE_BITS = 512,
  parameter int BEAT_BITS = 128,
  parameter int WAYS      = 4,
  parameter int LOBIT     = 6,
  parameter int TIMEOUT   = 255
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ihit,
  input  logic [AWID-1:0]                        miss_adr,
  input  logic [ASIDW-1:0]                       miss_asid,
  input  logic                                   invce,
  output logic                                   mem_req,
  output logic [AWID-1:0]                        mem_adr,
  output logic [ASIDW-1:0]                       mem_asid,
  input  logic                                   mem_ack,
  input  logic                                   mem_err,
  input  logic [BEAT_BITS-1:0]                   mem_dat,
  input  logic [AWID-1:0]                        mem_padr,
  output logic                                   wr_ic,
  output logic [(WAYS > 1 ? $clog2(WAYS) : 1)-1:0] wway,
  output logic [AWID-1:0]                        line_vtag,
  output logic [AWID-1:0]                        line_ptag,
  output logic [LINE_BITS-1:0]                   line_data,
  output logic                                   busy,
  output logic                                   err
);

  // state | meaning
  // IDLE  | waiting for ihit=0, latches the line address and ASID
  // FETCH | requesting beats; abort on bus error or ack timeout
  // WRITE | one-cycle cache write unless cancelled by invce
  // HOLD  | two cycles ignoring ihit while the cache registers the new line

  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int BSH   = $clog2(BEAT_BITS / 8);
  localparam logic [AWID-1:0] LINE_MASK = ~((AWID'(1) << LOBIT) - AWID'(1));

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, HOLD} state_t;

  state_t            state, state_nxt;
  logic [AWID-1:0]   ladr;
  logic [ASIDW-1:0]  masid;
  logic [BW-1:0]     beat;
  logic [TW-1:0]     tmo_cnt;
  logic [WW-1:0]     way_cnt;
  logic              cancel;
  logic              hold_cnt;
  logic [LOBIT-1:0]  beat_off;
  logic              ack_ok, abort, cancel_eff;

  assign ack_ok     = (state == FETCH) && mem_ack && !mem_err;
  assign abort      = (state == FETCH) &&
                      (mem_err || (!mem_ack && (tmo_cnt == TW'(TIMEOUT - 1))));
  // an invalidate arriving in the WRITE cycle itself must still cancel it
  assign cancel_eff = cancel || invce;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!ihit) state_nxt = FETCH;
      FETCH: begin
        if (abort)                                 state_nxt = IDLE;
        else if (ack_ok && beat == BW'(BEATS - 1)) state_nxt = WRITE;
      end
      WRITE: state_nxt = HOLD;
      HOLD:  if (hold_cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ladr      <= '0;
      masid     <= '0;
      beat      <= '0;
      tmo_cnt   <= '0;
      way_cnt   <= '0;
      cancel    <= 1'b0;
      hold_cnt  <= 1'b0;
      line_ptag <= '0;
      line_data <= '0;
      err       <= 1'b0;
    end else begin
      err <= abort;
      case (state)
        IDLE: begin
          if (!ihit) begin
            ladr    <= miss_adr & LINE_MASK;
            masid   <= miss_asid;
            beat    <= '0;
            tmo_cnt <= '0;
            cancel  <= 1'b0;
          end
        end
        FETCH: begin
          if (abort)      cancel <= 1'b0;
          else if (invce) cancel <= 1'b1;
          if (abort) begin
            tmo_cnt <= '0;
          end else if (ack_ok) begin
            line_data[int'(beat)*BEAT_BITS +: BEAT_BITS] <= mem_dat;
            if (beat == '0) line_ptag <= mem_padr & LINE_MASK;
            beat    <= beat + BW'(1);
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        WRITE: begin
          if (!cancel_eff)
            way_cnt <= (way_cnt == WW'(WAYS - 1)) ? '0 : way_cnt + WW'(1);
          cancel   <= 1'b0;
          hold_cnt <= 1'b0;
        end
        HOLD: hold_cnt <= 1'b1;
        default: ;
      endcase
    end
  end

  assign beat_off  = LOBIT'(beat) << BSH;
  assign mem_req   = (state == FETCH);
  assign mem_adr   = ladr | AWID'(beat_off);
  assign mem_asid  = masid;
  assign wr_ic     = (state == WRITE) && !cancel_eff;
  assign wway      = way_cnt;
  assign line_vtag = ladr;
  assign busy      = (state != IDLE);

endmodule

// File: doc/thor2023_icache_refill_ctrl.md
Name: thor2023_icache_refill_ctrl

Overview:
- Sequences instruction-cache refills: detects a fetch miss, reads the missing 64-byte line as fixed-size beats from the memory port, and assembles the line.
- Writes the assembled line into the cache with a round-robin way selection.
- Sits between the 4-way odd/even instruction cache (its miss_adr/miss_asid/ihit outputs and its ic_line_i/wway/wr_ic inputs) and the memory-side bus adapter.

Parameters:
- AWID, 32, address width (bits).
- ASIDW, 16, ASID width.
- LINE_BITS, 512, cache line data width.
- BEAT_BITS, 128, memory beat width; BEATS = LINE_BITS/BEAT_BITS (4).
- WAYS, 4, cache associativity; the wway width is $clog2(WAYS).
- LOBIT, 6, line offset bits; line address = miss_adr with bits [LOBIT-1:0] cleared.
- TIMEOUT, 255, maximum cycles allowed without mem_ack per beat before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- ihit  in  1  combined cache hit; 0 = miss pending.
- miss_adr  in  AWID  missing line address from the cache.
- miss_asid  in  ASIDW  ASID of the miss.
- invce  in  1  invalidate strobe from the cache (cancels the in-flight line write).
- mem_req  out  1  beat read request; held until ack/err.
- mem_adr  out  AWID  beat byte address.
- mem_asid  out  ASIDW  ASID for the translation.
- mem_ack  in  1  beat data valid.
- mem_err  in  1  bus error (dominates mem_ack).
- mem_dat  in  BEAT_BITS  beat data.
- mem_padr  in  AWID  physical address of the beat; sampled on the beat-0 ack.
- wr_ic  out  1  one-cycle cache write strobe.
- wway  out  $clog2(WAYS)  way to write.
- line_vtag  out  AWID  virtual line address for the write.
- line_ptag  out  AWID  physical line address for the write.
- line_data  out  LINE_BITS  assembled line.
- busy  out  1  controller is not IDLE.
- err  out  1  one-cycle pulse on abort (bus error or timeout).

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, way counter 0, beat counter 0, timeout counter 0, cancel flag 0. Assertion of rst in any state aborts the operation immediately and drops mem_req the same edge.
- IDLE:
  - When ihit=0, latch ladr = {miss_adr[AWID-1:LOBIT], LOBIT'b0} and masid = miss_asid; beat=0; go to FETCH next cycle.
  - ihit=1 keeps the controller in IDLE.
- FETCH:
  - mem_req=1, mem_adr = ladr + beat*(BEAT_BITS/8), mem_asid = masid.
  - Beat address and data index are modulo BEATS; no carry beyond the line.
  - mem_err (checked before mem_ack) -> pulse err, go to IDLE, no cache write.
  - Otherwise, on mem_ack: store mem_dat into line_data slice [beat*BEAT_BITS +: BEAT_BITS]. On beat 0, also capture line_ptag = {mem_padr[AWID-1:LOBIT], 0}. Then beat++ and reset the timeout counter.
  - mem_req stays 1 across consecutive beats, so back-to-back acks on successive cycles are accepted.
  - Ack on beat BEATS-1 -> WRITE.
  - The timeout counter increments each FETCH cycle without ack. When it reaches TIMEOUT: drop mem_req, pulse err, go to IDLE.
- Invalidate: invce seen in FETCH or WRITE sets the cancel flag.
- WRITE (1 cycle):
  - If the cancel flag is 0: wr_ic=1, wway=way counter, line_vtag=ladr; the way counter increments, wrapping WAYS-1 -> 0.
  - If the cancel flag is 1: wr_ic=0 and the way counter is unchanged.
  - Clear the cancel flag; go to HOLD.
- HOLD (2 cycles):
  - ihit is ignored, covering the cache's tag-read and hit registration latency so a just-written line is not re-fetched.
  - Then return to IDLE.
- Boundary conditions:
  - A miss on both the even and odd lines is handled as two sequential refills; the cache presents the even miss first.
  - A new miss during FETCH/WRITE/HOLD is ignored.
  - mem_ack outside FETCH is ignored.
  - line_data and the tags hold their last values after WRITE.
- Timing: busy = (state != IDLE). Minimum miss-to-wr_ic latency is 1 + BEATS cycles with zero-wait acks.

Test Plan:
- Reset, then ihit=0, miss_adr=0x0000_1234, zero-wait memory -> mem_adr sequence 0x1200, 0x1210, 0x1220, 0x1230; wr_ic pulses 5 cycles after miss detection with line_vtag=0x1200 and wway=0; busy falls 3 cycles after wr_ic.
- Four consecutive misses on distinct lines -> wway sequence 0,1,2,3, then 0 on the fifth; line_data equals the concatenated beats with beat 0 in bits [127:0].
- mem_err asserted together with mem_ack on beat 2 -> err pulses 1 cycle, no wr_ic, way counter unchanged, state IDLE the next cycle.
- No mem_ack for TIMEOUT=255 cycles on beat 0 -> mem_req drops, err pulses, no write; a following miss refetches from beat 0.
- invce pulsed during beat 1 -> all 4 beats are fetched, wr_ic stays 0, wway does not advance.
- rst asserted mid-FETCH (beat 2) -> mem_req, busy, and wr_ic go 0 asynchronously; after release with ihit=1 the controller stays IDLE with no memory traffic.
